// File: rtl/fc_result_writer.sv
// fc_result_writer: buffers FC neuron results and writes them in order to activation BRAM.
// Optional argmax tracking is built only when FC_ARGMAX_EN is defined.
module fc_result_writer #(
  parameter int BITWIDTH   = 8,
  parameter int NUM_NEURON = 84,
  parameter int ADDR_W     = 8,
  parameter int BASE_ADDR  = 0,
  parameter int FIFO_DEPTH = 4,
  parameter int IDX_W      = 8
) (
  input  logic                clk_x5,
  input  logic                rstn,
  input  logic                start,
  input  logic                valid_in,
  input  logic [BITWIDTH-1:0] result_in,
  output logic                in_ready,
  input  logic                bram_gnt,
  output logic                bram_we,
  output logic                bram_addren,
  output logic [ADDR_W-1:0]   bram_addr,
  output logic [BITWIDTH-1:0] bram_wdata,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic [IDX_W-1:0]    class_idx,
  output logic                class_valid
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(NUM_NEURON + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [BITWIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [PTR_W:0]      fcnt;
  logic [CNT_W-1:0]    acc_cnt, wr_cnt;
  logic                clr, push, pop, last_push;

  assign clr       = start && (state == IDLE || state == DONE);
  // ready looks only at the registered count, never at a same-cycle pop
  assign in_ready  = (state == RUN) && (fcnt != (PTR_W+1)'(FIFO_DEPTH));
  assign push      = valid_in && in_ready;
  assign pop       = (state == RUN || state == DRAIN)
                     && (fcnt != '0) && bram_gnt;
  assign last_push = push && (acc_cnt == CNT_W'(NUM_NEURON - 1));

  assign busy        = (state == RUN) || (state == DRAIN);
  assign done        = (state == DONE);
  assign bram_addren = bram_we;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE: if (start) state_nx = RUN;
      RUN:        if (last_push) state_nx = DRAIN;
      DRAIN: begin
        if (wr_cnt == CNT_W'(NUM_NEURON) && fcnt == '0)
          state_nx = DONE;
      end
      default:    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_x5) begin
    if (push) mem[wr_ptr] <= result_in;
  end

  always_ff @(posedge clk_x5 or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fcnt       <= '0;
      acc_cnt    <= '0;
      wr_cnt     <= '0;
      overflow   <= 1'b0;
      bram_we    <= 1'b0;
      bram_addr  <= '0;
      bram_wdata <= '0;
    end else begin
      state   <= state_nx;
      bram_we <= pop;
      if (clr) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        fcnt     <= '0;
        acc_cnt  <= '0;
        wr_cnt   <= '0;
        overflow <= 1'b0;
      end else begin
        if (push) begin
          wr_ptr  <= wr_ptr + 1'b1;
          acc_cnt <= acc_cnt + 1'b1;
        end
        if (pop) begin
          rd_ptr     <= rd_ptr + 1'b1;
          wr_cnt     <= wr_cnt + 1'b1;
          bram_addr  <= ADDR_W'(BASE_ADDR + int'(wr_cnt));
          bram_wdata <= mem[rd_ptr];
        end
        fcnt <= fcnt + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
        if (state == RUN && valid_in && !in_ready)
          overflow <= 1'b1;
      end
    end
  end

`ifdef FC_ARGMAX_EN
  logic [BITWIDTH-1:0] max_val;
  logic [IDX_W-1:0]    max_idx;

  // strict compare keeps the lowest index on ties
  always_ff @(posedge clk_x5 or negedge rstn) begin
    if (!rstn) begin
      max_val <= '0;
      max_idx <= '0;
    end else if (clr) begin
      max_val <= '0;
      max_idx <= '0;
    end else if (push && (acc_cnt == '0 || result_in > max_val)) begin
      max_val <= result_in;
      max_idx <= IDX_W'(acc_cnt);
    end
  end

  assign class_idx   = max_idx;
  assign class_valid = done;
`else
  assign class_idx   = '0;
  assign class_valid = 1'b0;
`endif

endmodule

// File: tb/tb_fc_result_writer.sv
// tb_fc_result_writer: randomized self-checking bench for fc_result_writer.
// A queue-based model predicts BRAM writes, timing and argmax.
module tb_fc_result_writer;

  localparam int N    = 6;
  localparam int BASE = 253;

  logic       clk_x5, rstn, start, valid_in, bram_gnt;
  logic [7:0] result_in;
  logic       in_ready, bram_we, bram_addren, busy, done, overflow;
  logic [7:0] bram_addr, bram_wdata, class_idx;
  logic       class_valid;

  int  tests = 0;
  int  fails = 0;
  bit  rgnt  = 0;
  bit  done_seen = 0;
  time done_time, first_drive;
  logic [7:0] w_addr[$];
  logic [7:0] w_data[$];
  time        w_time[$];

  fc_result_writer #(
    .BITWIDTH(8), .NUM_NEURON(N), .ADDR_W(8),
    .BASE_ADDR(BASE), .FIFO_DEPTH(4), .IDX_W(8)
  ) dut (
    .clk_x5(clk_x5), .rstn(rstn), .start(start),
    .valid_in(valid_in), .result_in(result_in),
    .in_ready(in_ready), .bram_gnt(bram_gnt),
    .bram_we(bram_we), .bram_addren(bram_addren),
    .bram_addr(bram_addr), .bram_wdata(bram_wdata),
    .busy(busy), .done(done), .overflow(overflow),
    .class_idx(class_idx), .class_valid(class_valid)
  );

  initial clk_x5 = 1'b0;
  always #5 clk_x5 = ~clk_x5;

  always @(negedge clk_x5) begin
    if (bram_we) begin
      w_addr.push_back(bram_addr);
      w_data.push_back(bram_wdata);
      w_time.push_back($time);
    end
    if (done && !done_seen) begin
      done_seen = 1;
      done_time = $time;
    end
  end

  function automatic int argmax(input logic [7:0] v[$]);
    int k = 0;
    for (int i = 1; i < v.size(); i++) if (v[i] > v[k]) k = i;
    return k;
  endfunction

  task automatic start_run();
    @(negedge clk_x5);
    start = 1'b1;
    w_addr.delete(); w_data.delete(); w_time.delete();
    @(negedge clk_x5);
    start = 1'b0;
    done_seen = 0;
  endtask

  task automatic feed(input logic [7:0] v[$], input int gap);
    int i = 0;
    int guard = 0;
    while (i < v.size() && guard < 2000) begin
      @(negedge clk_x5);
      guard++;
      valid_in = 1'b0;
      if (rgnt) bram_gnt = ($urandom_range(3, 0) != 0);
      if (in_ready && $urandom_range(gap, 0) == 0) begin
        valid_in  = 1'b1;
        result_in = v[i];
        if (i == 0) first_drive = $time;
        i++;
      end
    end
    @(negedge clk_x5);
    valid_in = 1'b0;
    tests++;
    if (i < v.size()) begin
      fails++;
      $display("FAIL feed_timeout: sent %0d want %0d", i, v.size());
    end
  endtask

  task automatic wait_done(input string nm);
    int g = 0;
    while (!done && g < 500) begin
      @(negedge clk_x5);
      if (rgnt) bram_gnt = ($urandom_range(3, 0) != 0);
      g++;
    end
    @(negedge clk_x5);
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL %s_done_timeout: done=%b want 1", nm, done);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b1;
    #2 rstn = 1'b0;
    #1;
    tests++;
    if ({in_ready, bram_we, bram_addren, bram_addr, bram_wdata, busy,
         done, overflow, class_idx, class_valid} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: we=%b addr=%h data=%h busy=%b done=%b ovf=%b",
               bram_we, bram_addr, bram_wdata, busy, done, overflow);
    end
    repeat (2) @(negedge clk_x5);
    rstn = 1'b1;
    @(posedge clk_x5);
    #1;
    tests++;
    if ({bram_we, busy, done, in_ready} !== 4'b0) begin
      fails++;
      $display("FAIL reset_release: we=%b busy=%b done=%b rdy=%b want 0",
               bram_we, busy, done, in_ready);
    end
  endtask

  task automatic test_basic();
    logic [7:0] v[$];
    v = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60};
    bram_gnt = 1'b1;
    start_run();
    feed(v, 0);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL basic_busy: got %b want 1", busy);
    end
    wait_done("basic");
    tests++;
    if (w_data.size() != N) begin
      fails++;
      $display("FAIL basic_count: got %0d want %0d", w_data.size(), N);
    end
    for (int i = 0; i < N && i < w_data.size(); i++) begin
      tests++;
      if (w_addr[i] !== 8'(BASE + i) || w_data[i] !== v[i]) begin
        fails++;
        $display("FAIL basic_write[%0d]: got %0d/%0d want %0d/%0d",
                 i, w_addr[i], w_data[i], 8'(BASE + i), v[i]);
      end
    end
    if (w_time.size() == N) begin
      tests++;
      if (w_time[0] != first_drive + 20) begin
        fails++;
        $display("FAIL basic_latency: got %0t want %0t", w_time[0], first_drive + 20);
      end
      tests++;
      if (w_time[N-1] - w_time[0] != (N - 1) * 10) begin
        fails++;
        $display("FAIL basic_b2b: span %0t want %0d", w_time[N-1] - w_time[0], (N - 1) * 10);
      end
      tests++;
      if (done_time != w_time[N-1] + 10) begin
        fails++;
        $display("FAIL basic_done_time: got %0t want %0t", done_time, w_time[N-1] + 10);
      end
    end
    tests++;
    if ({busy, overflow} !== 2'b00) begin
      fails++;
      $display("FAIL basic_end: busy=%b ovf=%b want 0 0", busy, overflow);
    end
  endtask

  task automatic test_stall();
    logic [7:0] v[$];
    logic [7:0] t[$];
    v = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    t = '{8'h77, 8'h88};
    bram_gnt = 1'b0;
    start_run();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_x5);
      if (i == 3) begin
        tests++;
        if (overflow !== 1'b0) begin
          fails++;
          $display("FAIL stall_ovf_early: got %b want 0", overflow);
        end
      end
      if (i == 4) begin
        tests++;
        if (in_ready !== 1'b0) begin
          fails++;
          $display("FAIL stall_ready: got %b want 0", in_ready);
        end
      end
      valid_in  = 1'b1;
      result_in = v[i];
    end
    @(negedge clk_x5);
    valid_in = 1'b0;
    tests++;
    if (overflow !== 1'b1 || w_data.size() != 0) begin
      fails++;
      $display("FAIL stall_hold: ovf=%b writes=%0d want 1 0", overflow, w_data.size());
    end
    bram_gnt = 1'b1;
    repeat (8) @(negedge clk_x5);
    tests++;
    if (w_data.size() != 4) begin
      fails++;
      $display("FAIL stall_release_count: got %0d want 4", w_data.size());
    end
    feed(t, 0);
    wait_done("stall");
    v[4] = t[0];
    v[5] = t[1];
    tests++;
    if (w_data.size() != N) begin
      fails++;
      $display("FAIL stall_count: got %0d want %0d", w_data.size(), N);
    end
    for (int i = 0; i < N && i < w_data.size(); i++) begin
      tests++;
      if (w_addr[i] !== 8'(BASE + i) || w_data[i] !== v[i]) begin
        fails++;
        $display("FAIL stall_write[%0d]: got %0d/%h want %0d/%h",
                 i, w_addr[i], w_data[i], 8'(BASE + i), v[i]);
      end
    end
    tests++;
    if (overflow !== 1'b1) begin
      fails++;
      $display("FAIL stall_ovf_sticky: got %b want 1", overflow);
    end
  endtask

  task automatic test_reset_drain();
    logic [7:0] a[$];
    logic [7:0] b[$];
    logic [7:0] v[$];
    a = '{8'd1, 8'd2, 8'd3, 8'd4};
    b = '{8'd5, 8'd6};
    bram_gnt = 1'b1;
    start_run();
    feed(a, 0);
    repeat (4) @(negedge clk_x5);
    bram_gnt = 1'b0;
    feed(b, 0);
    tests++;
    if ({busy, in_ready} !== 2'b10) begin
      fails++;
      $display("FAIL rstdrain_state: busy=%b rdy=%b want 1 0", busy, in_ready);
    end
    #2 rstn = 1'b0;
    #1;
    tests++;
    if ({in_ready, bram_we, bram_addren, bram_addr, bram_wdata, busy,
         done, overflow, class_idx, class_valid} !== '0) begin
      fails++;
      $display("FAIL rstdrain_outputs: we=%b addr=%h data=%h busy=%b",
               bram_we, bram_addr, bram_wdata, busy);
    end
    w_addr.delete(); w_data.delete(); w_time.delete();
    repeat (2) @(negedge clk_x5);
    bram_gnt = 1'b1;
    rstn = 1'b1;
    repeat (6) @(negedge clk_x5);
    tests++;
    if (w_data.size() != 0 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL rstdrain_quiet: writes=%0d busy=%b done=%b want 0",
               w_data.size(), busy, done);
    end
    for (int i = 0; i < N; i++) v.push_back(8'($urandom_range(255, 0)));
    start_run();
    feed(v, 1);
    wait_done("rstdrain");
    tests++;
    if (w_data.size() != N) begin
      fails++;
      $display("FAIL rstdrain_count: got %0d want %0d", w_data.size(), N);
    end
    for (int i = 0; i < N && i < w_data.size(); i++) begin
      tests++;
      if (w_addr[i] !== 8'(BASE + i) || w_data[i] !== v[i]) begin
        fails++;
        $display("FAIL rstdrain_write[%0d]: got %0d/%0d want %0d/%0d",
                 i, w_addr[i], w_data[i], 8'(BASE + i), v[i]);
      end
    end
  endtask

  task automatic test_argmax();
    logic [7:0] v[$];
    logic [7:0] ei;
    logic       ev;
    v = '{8'd5, 8'd90, 8'd90, 8'd12, 8'd7, 8'd3};
`ifdef FC_ARGMAX_EN
    ei = 8'(argmax(v));
    ev = 1'b1;
`else
    ei = 8'd0;
    ev = 1'b0;
`endif
    bram_gnt = 1'b1;
    start_run();
    tests++;
    if (class_valid !== 1'b0) begin
      fails++;
      $display("FAIL argmax_clear: class_valid=%b want 0", class_valid);
    end
    feed(v, 0);
    tests++;
    if (class_valid !== 1'b0) begin
      fails++;
      $display("FAIL argmax_early: class_valid=%b want 0", class_valid);
    end
    wait_done("argmax");
    tests++;
    if (class_idx !== ei || class_valid !== ev) begin
      fails++;
      $display("FAIL argmax_result: idx=%0d valid=%b want %0d %b",
               class_idx, class_valid, ei, ev);
    end
  endtask

  task automatic test_extra();
    logic [7:0] a[$];
    logic [7:0] b[$];
    logic [7:0] v[$];
    a = '{8'hA1, 8'hA2, 8'hA3};
    b = '{8'hB1, 8'hB2, 8'hB3};
    v = '{8'hA1, 8'hA2, 8'hA3, 8'hB1, 8'hB2, 8'hB3};
    bram_gnt = 1'b1;
    start_run();
    feed(a, 0);
    @(negedge clk_x5);
    start = 1'b1;
    @(negedge clk_x5);
    start = 1'b0;
    feed(b, 0);
    repeat (3) begin
      valid_in  = 1'b1;
      result_in = 8'hEE;
      @(negedge clk_x5);
    end
    valid_in = 1'b0;
    wait_done("extra");
    repeat (3) @(negedge clk_x5);
    tests++;
    if (overflow !== 1'b0 || w_data.size() != N) begin
      fails++;
      $display("FAIL extra_ignored: ovf=%b writes=%0d want 0 %0d",
               overflow, w_data.size(), N);
    end
    for (int i = 0; i < N && i < w_data.size(); i++) begin
      tests++;
      if (w_addr[i] !== 8'(BASE + i) || w_data[i] !== v[i]) begin
        fails++;
        $display("FAIL extra_write[%0d]: got %0d/%h want %0d/%h",
                 i, w_addr[i], w_data[i], 8'(BASE + i), v[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] v[$];
    logic [7:0] ei;
    logic       ev;
    rgnt = 1;
    for (int it = 0; it < 6; it++) begin
      v.delete();
      for (int i = 0; i < N; i++) v.push_back(8'($urandom_range(9, 0) * 25));
`ifdef FC_ARGMAX_EN
      ei = 8'(argmax(v));
      ev = 1'b1;
`else
      ei = 8'd0;
      ev = 1'b0;
`endif
      start_run();
      feed(v, 2);
      wait_done("random");
      tests++;
      if (w_data.size() != N || overflow !== 1'b0) begin
        fails++;
        $display("FAIL random_count[%0d]: writes=%0d ovf=%b want %0d 0",
                 it, w_data.size(), overflow, N);
      end
      for (int i = 0; i < N && i < w_data.size(); i++) begin
        tests++;
        if (w_addr[i] !== 8'(BASE + i) || w_data[i] !== v[i]) begin
          fails++;
          $display("FAIL random_write[%0d.%0d]: got %0d/%0d want %0d/%0d",
                   it, i, w_addr[i], w_data[i], 8'(BASE + i), v[i]);
        end
      end
      tests++;
      if (class_idx !== ei || class_valid !== ev) begin
        fails++;
        $display("FAIL random_argmax[%0d]: idx=%0d valid=%b want %0d %b",
                 it, class_idx, class_valid, ei, ev);
      end
    end
    rgnt = 0;
    bram_gnt = 1'b1;
  endtask

  initial begin
    rstn      = 1'b1;
    start     = 1'b0;
    valid_in  = 1'b0;
    result_in = '0;
    bram_gnt  = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_reset_drain();
    test_argmax();
    test_extra();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fc_result_writer.md
Name: fc_result_writer

Overview:
Write-side counterpart to the FC layer read sequencer. It collects per-neuron results from the Full_Connect datapath through a valid/ready handshake and buffers them in a small FIFO. It then writes them as sequential 8-bit words into an activation BRAM, the same BRAM style as FLATTEN, so the next layer can read them. It arbitrates for the shared single-port BRAM with a grant input and reports completion.

Parameters:
BITWIDTH, 8, width of result and BRAM word
NUM_NEURON, 84, results to accept and write per run (>=1)
ADDR_W, 8, BRAM address width
BASE_ADDR, 0, BRAM address of neuron 0
FIFO_DEPTH, 4, skid FIFO entries (power of 2, >=2)
IDX_W, 8, width of neuron index / class output

Ports:
clk_x5  in  1  clock, all logic on posedge
rstn  in  1  reset, asynchronous, active-low
start  in  1  one-cycle pulse, begins a run
valid_in  in  1  result_in valid this cycle
result_in  in  BITWIDTH  unsigned neuron result
in_ready  out  1  FIFO can accept (not full and state RUN)
bram_gnt  in  1  BRAM port granted to writer this cycle
bram_we  out  1  write strobe, registered
bram_addren  out  1  address enable, equals bram_we
bram_addr  out  ADDR_W  write address, registered
bram_wdata  out  BITWIDTH  write data, registered
busy  out  1  state RUN or DRAIN
done  out  1  run complete, held until next start
overflow  out  1  sticky: valid_in seen while in_ready low in RUN
class_idx  out  IDX_W  argmax index (optional feature)
class_valid  out  1  class_idx valid (optional feature)

Behaviour:
- Reset (async, rstn low): state IDLE. FIFO emptied. acc_cnt=0, wr_cnt=0. Every output 0. An in-flight BRAM write is abandoned; bram_we is 0 on the first clock after reset release.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE + start -> RUN. Clears acc_cnt, wr_cnt, FIFO, done, overflow and argmax state.
- start while in RUN or DRAIN is ignored.
- RUN: push when valid_in && in_ready; acc_cnt++ on each push.
- The push that makes acc_cnt==NUM_NEURON moves to DRAIN on the next cycle. in_ready is 0 from that cycle on.
- valid_in while in_ready=0 in RUN sets overflow; the data is dropped.
- valid_in outside RUN is ignored silently; overflow is not set.
- Write side (RUN or DRAIN): when FIFO is non-empty and bram_gnt=1, pop the head. Next cycle: bram_we=bram_addren=1, bram_addr=(BASE_ADDR+wr_cnt) mod 2^ADDR_W, bram_wdata=head. wr_cnt++.
- Otherwise bram_we=bram_addren=0. bram_addr and bram_wdata hold their last values.
- Exactly one write per cycle at most.
- Push and pop in the same cycle are allowed. With the FIFO full, a same-cycle pop does not free in_ready; in_ready depends only on registered count.
- Latency: a result accepted at edge t into an empty FIFO with bram_gnt high reaches bram_we=1 at edge t+2.
- bram_gnt low stalls the write side indefinitely. Data order is preserved and nothing is lost.
- DRAIN -> DONE when wr_cnt==NUM_NEURON and FIFO empty. done rises in the cycle after the last bram_we.
- Writes are strictly in acceptance order: neuron i goes to BASE_ADDR+i.

Optional Feature:
FC_ARGMAX_EN.
- Defined: on each push, compare result_in (unsigned) against the running max. A strictly greater value updates max and idx=acc_cnt, so ties keep the lowest index. The first push always loads.
- With the feature defined, class_idx is registered and class_valid=1 together with done. Both clear on start.
- Not defined: class_idx=0 and class_valid=0 permanently. No comparator logic is built.

Test Plan:
1. Reset, then start with NUM_NEURON=4, bram_gnt=1, results 10,20,30,40 back-to-back -> writes to addresses 0..3 with data 10,20,30,40. First bram_we 2 cycles after the first accept. done 1 cycle after the last write; busy=0.
2. bram_gnt=0 while 6 results are offered (FIFO_DEPTH=4) -> in_ready drops after 4 pushes, overflow=1, no bram_we. Raise bram_gnt -> 4 writes of the first 4 values in order.
3. BASE_ADDR=254, ADDR_W=8, NUM_NEURON=4 -> write addresses 254, 255, 0, 1.
4. rstn low mid-DRAIN with 2 entries pending -> all outputs 0 immediately. No writes after release. A new start with 3 results runs cleanly from address BASE_ADDR.
5. FC_ARGMAX_EN defined, results 5,90,90,12 -> class_idx=1, class_valid=1 with done. With the macro undefined, class_valid stays 0.
6. Extra valid_in after the NUM_NEURON-th accept, and start pulse during RUN -> both ignored, overflow stays 0, exactly NUM_NEURON writes.
